// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the NES sprite (OAM) DMA controller.
package nes_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

  // Bytes per transfer; must be a power of two no larger than 256.
  localparam int unsigned XFER_LEN = 256;
  localparam int unsigned IDX_W    = $clog2(XFER_LEN);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } dma_state_e;

endpackage

// File: rtl/oam_dma_addr_gen.sv
// Source address generator for OAM DMA: page latch, byte index counter and
// {page,index} address formation.
module oam_dma_addr_gen
  import nes_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  page_value,
  input  logic        advance,
  output logic [15:0] address,
  output logic [15:0] next_address,
  output logic        last
);

  logic [7:0]       page;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_inc;

  assign index_inc    = index + IDX_W'(1);
  assign last         = (index == IDX_W'(XFER_LEN - 1));
  // Index is zero-extended into the low byte, so no carry ever reaches the page.
  assign address      = {page, 8'(index)};
  assign next_address = {page, 8'(index_inc)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page  <= 8'h00;
      index <= '0;
    end else begin
      if (load) begin
        page <= page_value;
      end
      if (advance) begin
        index <= index_inc;
      end
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// NES OAM DMA sequencer: halts the 6502 via RDY and copies one CPU page to the
// PPU OAM data port. Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN state.
module oam_dma_controller
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_cpu_address,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_cpu_rdy,
  output logic        o_bus_select,
  output logic [15:0] o_bus_address,
  output logic        o_bus_rw,
  output logic [7:0]  o_bus_data,
  output logic        o_busy
);

  dma_state_e  state;
  logic        load;
  logic        advance;
  logic        last;
  logic        need_align;
  logic [15:0] src_address;
  logic [15:0] next_address;

  // Only IDLE accepts a trigger, so the page cannot be re-latched mid-transfer.
  assign load    = (state == IDLE) && !i_cpu_rw && (i_cpu_address == DMA_REG_ADDR);
  assign advance = (state == WRITE);

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end

  assign need_align = parity;
`else
  assign need_align = 1'b0;
`endif

  oam_dma_addr_gen u_addr_gen (
    .clk          (i_clk),
    .reset_n      (i_reset_n),
    .load         (load),
    .page_value   (i_cpu_data),
    .advance      (advance),
    .address      (src_address),
    .next_address (next_address),
    .last         (last)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      o_cpu_rdy     <= 1'b1;
      o_bus_select  <= 1'b0;
      o_bus_address <= 16'h0000;
      o_bus_rw      <= 1'b1;
      o_bus_data    <= 8'h00;
      o_busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= HALT;
            o_busy    <= 1'b1;
            o_cpu_rdy <= 1'b0;
          end
        end
        HALT: begin
          // The 6502 ignores RDY on write cycles; wait for a real read stall.
          if (i_cpu_rw) begin
            o_bus_select <= 1'b1;
            o_bus_rw     <= 1'b1;
            if (need_align) begin
              state <= ALIGN;
            end else begin
              state         <= READ;
              o_bus_address <= src_address;
            end
          end
        end
        ALIGN: begin
          state         <= READ;
          o_bus_address <= src_address;
        end
        READ: begin
          state         <= WRITE;
          o_bus_rw      <= 1'b0;
          o_bus_address <= OAM_DATA_ADDR;
          o_bus_data    <= i_bus_data;
        end
        WRITE: begin
          o_bus_rw <= 1'b1;
          if (last) begin
            state        <= DONE;
            o_bus_select <= 1'b0;
            o_busy       <= 1'b0;
          end else begin
            state         <= READ;
            o_bus_address <= next_address;
          end
        end
        DONE: begin
          state     <= IDLE;
          o_cpu_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller; honours OAM_DMA_ALIGN_EN when defined.
module tb_oam_dma_controller;
  import nes_dma_pkg::*;

`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_EXTRA = 1;
`else
  localparam int ALIGN_EXTRA = 0;
`endif
  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_REG = 16'h2004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_address = 16'h0000;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_data = 8'h00;
  logic [7:0]  bus_data_in;
  logic        cpu_rdy;
  logic        bus_select;
  logic [15:0] bus_address;
  logic        bus_rw;
  logic [7:0]  bus_data_out;
  logic        busy;

  logic [7:0] mem [0:65535];
  assign bus_data_in = mem[bus_address];

  always #5 clk = ~clk;

  oam_dma_controller dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_cpu_address (cpu_address),
    .i_cpu_rw      (cpu_rw),
    .i_cpu_data    (cpu_data),
    .i_bus_data    (bus_data_in),
    .o_cpu_rdy     (cpu_rdy),
    .o_bus_select  (bus_select),
    .o_bus_address (bus_address),
    .o_bus_rw      (bus_rw),
    .o_bus_data    (bus_data_out),
    .o_busy        (busy)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle parity model: a toggle that starts at 0 after reset.
  int unsigned edge_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Bus observer: every write cycle pairs with the read cycle right before it.
  logic [15:0] rd_q[$];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  int unsigned rd_cycles = 0;
  logic        prev_read = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_read = 1'b0;
    end else begin
      if (bus_select && !bus_rw) begin
        if (prev_read) rd_q.push_back(prev_addr);
        wr_a_q.push_back(bus_address);
        wr_d_q.push_back(bus_data_out);
      end
      if (bus_select && bus_rw) rd_cycles++;
      prev_read = bus_select && bus_rw;
      prev_addr = bus_address;
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
    cpu_address = a;
    cpu_rw      = rw;
    cpu_data    = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] page;
    int         nw;
    bit         odd;
    bit         inject;
    int         exp_stall;
  } vec_t;

  task automatic run_dma(input vec_t v, input string tag);
    int          stall;
    int          errs;
    logic [15:0] ea;
    if (((edge_cnt + 1 + v.nw) % 2) != v.odd) cpu_cycle(16'h8000, 1'b1, 8'h00);
    rd_q.delete();
    wr_a_q.delete();
    wr_d_q.delete();
    rd_cycles = 0;
    cpu_cycle(DMA_REG, 1'b0, v.page);
    chk({tag, "_rdy_low"}, cpu_rdy, 1'b0);
    chk({tag, "_busy_high"}, busy, 1'b1);
    for (int i = 0; i < v.nw; i++) begin
      cpu_cycle(16'h01FD - 16'(i), 1'b0, 8'hA5);
      chk({tag, "_halt_hold_sel"}, bus_select, 1'b0);
    end
    cpu_cycle(16'h8001, 1'b1, 8'h00);
    chk({tag, "_claim_sel"}, bus_select, 1'b1);
    stall = 0;
    while (!cpu_rdy && stall < 1000) begin
      if (v.inject && stall == 50) cpu_cycle(DMA_REG, 1'b0, 8'h77);
      else                         cpu_cycle(16'h8002, 1'b1, 8'h00);
      stall++;
    end
    chk({tag, "_stall"}, stall, v.exp_stall);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_sel_end"}, bus_select, 1'b0);
    chk({tag, "_rw_end"}, bus_rw, 1'b1);
    chk({tag, "_nwrites"}, wr_a_q.size(), XFER_LEN);
    chk({tag, "_nreads"}, rd_q.size(), XFER_LEN);
    chk({tag, "_align_cycles"}, rd_cycles - rd_q.size(), v.odd ? ALIGN_EXTRA : 0);
    if (rd_q.size() > 0) begin
      chk({tag, "_first_read"}, rd_q[0], {v.page, 8'h00});
      chk({tag, "_last_read"}, rd_q[rd_q.size() - 1], {v.page, 8'hFF});
    end
    errs = 0;
    for (int i = 0; i < XFER_LEN; i++) begin
      ea = {v.page, i[7:0]};
      if (i >= rd_q.size() || rd_q[i] !== ea) errs++;
      if (i >= wr_a_q.size() || wr_a_q[i] !== OAM_REG || wr_d_q[i] !== mem[ea]) errs++;
    end
    chk({tag, "_xfer_errors"}, errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t rv;
    int   wcnt;
    int   guard;

    vecs[0] = '{8'h02, 0, 1'b0, 1'b0, 513};
    vecs[1] = '{8'h02, 0, 1'b1, 1'b0, 513 + ALIGN_EXTRA};
    vecs[2] = '{8'h03, 2, 1'b0, 1'b0, 513};
    vecs[3] = '{8'h03, 2, 1'b1, 1'b0, 513 + ALIGN_EXTRA};
    vecs[4] = '{8'hFF, 0, 1'b1, 1'b0, 513 + ALIGN_EXTRA};
    vecs[5] = '{8'h10, 1, 1'b0, 1'b1, 513};

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 256; a++)   mem[16'hFF00 + a] = ~a[7:0];

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", cpu_rdy, 1'b1);
    chk("reset_sel", bus_select, 1'b0);
    chk("reset_addr", bus_address, 16'h0000);
    chk("reset_rw", bus_rw, 1'b1);
    chk("reset_data", bus_data_out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    cpu_cycle(16'h8000, 1'b1, 8'h00);

    for (int k = 0; k < 6; k++) run_dma(vecs[k], $sformatf("v%0d", k));

    for (int k = 0; k < 4; k++) begin
      rv.page      = 8'($urandom_range(0, 255));
      rv.nw        = int'($urandom_range(0, 3));
      rv.odd       = 1'($urandom_range(0, 1));
      rv.inject    = 1'($urandom_range(0, 1));
      rv.exp_stall = 513 + (rv.odd ? ALIGN_EXTRA : 0);
      run_dma(rv, $sformatf("rnd%0d", k));
    end

    // Abort with reset in the WRITE cycle of byte 100, then restart cleanly.
    if (((edge_cnt + 1) % 2) != 0) cpu_cycle(16'h8000, 1'b1, 8'h00);
    cpu_cycle(DMA_REG, 1'b0, 8'h04);
    cpu_cycle(16'h8001, 1'b1, 8'h00);
    wcnt = 0;
    guard = 0;
    while (wcnt < 101 && guard < 1000) begin
      cpu_cycle(16'h8002, 1'b1, 8'h00);
      guard++;
      if (bus_select && !bus_rw) wcnt++;
    end
    chk("abort_in_write", bus_address, OAM_REG);
    chk("abort_byte100", bus_data_out, mem[16'h0464]);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", cpu_rdy, 1'b1);
    chk("abort_sel", bus_select, 1'b0);
    chk("abort_addr", bus_address, 16'h0000);
    chk("abort_rw", bus_rw, 1'b1);
    chk("abort_data", bus_data_out, 8'h00);
    chk("abort_busy", busy, 1'b0);
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    rst_n = 1'b1;
    cpu_cycle(16'h8000, 1'b1, 8'h00);
    rv = '{8'h05, 0, 1'b0, 1'b0, 513};
    run_dma(rv, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the NES sprite (OAM) DMA transfer.
- A CPU write to the DMA register halts the 6502 through RDY and takes ownership of the external CPU bus: address, R/W, and the data driven behind the data output register.
- It then copies 256 bytes from a CPU page to the PPU OAM data port.
- It sits between the 6502 core and the system bus mux; o_bus_select steers the mux.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every write cycle.
- XFER_LEN, 256, bytes per transfer. Must be a power of two, ≤256.

Ports:
- i_clk  input  1  CPU clock; one rising edge = one CPU cycle
- i_reset_n  input  1  asynchronous active-low reset
- i_cpu_address  input  16  address from the 6502
- i_cpu_rw  input  1  6502 R/W (read = HIGH, write = LOW)
- i_cpu_data  input  8  data the 6502 is writing this cycle
- i_bus_data  input  8  read data returned from the system bus
- o_cpu_rdy  output  1  6502 RDY; LOW halts the CPU on its next read cycle
- o_bus_select  output  1  HIGH = DMA owns the bus and the mux selects o_bus_*
- o_bus_address  output  16  DMA address
- o_bus_rw  output  1  DMA R/W (HIGH read, LOW write)
- o_bus_data  output  8  DMA write data
- o_busy  output  1  HIGH from trigger until the final write completes

Behaviour:
- Reset values: o_cpu_rdy=1, o_bus_select=0, o_bus_address=0, o_bus_rw=1, o_bus_data=0, o_busy=0; state=IDLE, index=0, parity=0.
- Reset mid-transfer aborts immediately to these values. No partial-transfer recovery.
- parity: a free-running 1-bit toggle on every clock (0 = even/get cycle, 1 = odd/put cycle).
- All outputs are registered.
- States:
  - IDLE: on a rising edge where i_cpu_rw=0 and i_cpu_address==DMA_REG_ADDR, latch page=i_cpu_data, set o_busy=1, o_cpu_rdy=0, go to HALT.
  - HALT: wait until a cycle where i_cpu_rw=1 (the CPU is actually stalled; the 6502 ignores RDY on writes). That cycle is the halt cycle. Then go to ALIGN if parity==1, else READ.
  - ALIGN: one dummy cycle; o_bus_select=1, o_bus_rw=1, address unchanged. Then go to READ.
  - READ: o_bus_select=1, o_bus_rw=1, o_bus_address={page,index}. Capture i_bus_data into the byte latch at the closing edge. Then go to WRITE.
  - WRITE: o_bus_rw=0, o_bus_address=OAM_DATA_ADDR, o_bus_data=latched byte. Then increment index.
    - If index was XFER_LEN-1: wrap index to 0 and go to DONE.
    - Otherwise go to READ.
  - DONE: o_bus_select=0, o_bus_rw=1, o_cpu_rdy=1, o_busy=0, then return to IDLE.
- Total stall, halt edge to RDY release: 513 cycles if the halt cycle is even, 514 if odd (with alignment enabled).
- Triggers seen while o_busy=1 are ignored. The page is never re-latched mid-transfer.
- Page $FF reads $FF00–$FFFF. The address never carries into the page byte.
- Consecutive CPU writes in HALT (e.g. RMW or interrupt stack pushes) extend HALT without bound until a read cycle occurs.
- A trigger in the same cycle that DONE returns to IDLE is not accepted; the CPU is still stalled, so this cannot occur legally.

Optional Feature:
- Macro OAM_DMA_ALIGN_EN.
- Defined: the ALIGN state is inserted when the halt cycle has parity==1, so every READ lands on a get cycle (hardware-accurate 513/514 cycles).
- Undefined: ALIGN is removed and READ always follows HALT. The stall is a fixed 513 cycles and the parity register may be optimised away.

Decomposition:
- Shared package nes_dma_pkg holds:
  - the state enum (IDLE, HALT, ALIGN, READ, WRITE, DONE);
  - DMA_REG_ADDR and OAM_DATA_ADDR defaults;
  - XFER_LEN;
  - the index width constant.
- One sub-module is natural: oam_dma_addr_gen. It holds the page latch, the index counter with wrap/last flag, and the {page,index} address formation.
- The FSM stays in the top.

Test Plan:
- Reset, then write $02 to $4014 on an even parity cycle, followed by a CPU read. Expect:
  - o_cpu_rdy falls the next cycle;
  - first READ address $0200;
  - 256 writes to $2004 with data equal to memory $0200–$02FF;
  - RDY high again after 513 cycles.
- Same trigger with the halt cycle on odd parity and OAM_DMA_ALIGN_EN defined → one ALIGN cycle, stall = 514. With the macro undefined → stall = 513.
- Trigger followed by two CPU write cycles (e.g. JSR push) → HALT holds for both, and the bus is claimed only on the first i_cpu_rw=1 cycle.
- Page $FF with memory pattern byte=~addr[7:0] → last read at $FFFF, no wrap into $0000, index returns to 0.
- Assert i_reset_n low during WRITE of byte 100 → all outputs return to reset values asynchronously. A fresh trigger afterwards restarts from index 0.
- Second write to $4014 during the transfer (forced on i_cpu_*) → ignored, page unchanged, byte count stays 256.
